rmst_burst_engine: RTL and testbench

RMST_BURST_ENGINE -- requirements
Module: rmst_burst_engine

---
 rtl/rmst_burst_engine.sv | 130 +++++++++++++
 tb/tb_rmst_burst_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmst_burst_engine.sv
// rmst_burst_engine: fetches one row segment as a series of Avalon-MM read
// bursts and forwards every returned beat to the load FIFO, one cycle late.
module rmst_burst_engine #(
  parameter int XAW       = 32,
  parameter int XDW       = 128,
  parameter int CW        = 16,
  parameter int MAX_BURST = 16,
  parameter int BW        = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_trans_start,
  input  logic [XAW-1:0] param_raddr,
  input  logic [CW-1:0]  param_iolen,
  output logic           load_trans_done,
  output logic [XAW-1:0] avm_address,
  output logic           avm_read,
  output logic [BW-1:0]  avm_burstcount,
  input  logic           avm_waitrequest,
  input  logic [XDW-1:0] avm_readdata,
  input  logic           avm_readdatavalid,
  output logic           fifo_wr,
  output logic [XDW-1:0] fifo_wdata,
  output logic           busy
);

  localparam int LG = $clog2(XDW / 8);
  localparam logic [XAW-1:0] AMASK = ~XAW'(XDW / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DATA,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [XAW-1:0] addr_q, addr_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [BW-1:0]  beats_q, beats_d;
  logic           done_q;
  logic           wr_q;
  logic [XDW-1:0] wdata_q;
  logic [BW-1:0]  bc_w;
  logic           beat_ok;

  // Size of the next burst: whatever is left, capped at MAX_BURST.
  always_comb begin
    if (rem_q >= CW'(MAX_BURST)) begin
      bc_w = BW'(MAX_BURST);
    end else begin
      bc_w = rem_q[BW-1:0];
    end
  end

  // Beats are only forwarded while a segment is in flight.
  assign beat_ok = avm_readdatavalid &&
                   ((state_q == S_ISSUE) || (state_q == S_DATA));

  // Next-state logic and burst bookkeeping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_trans_start) begin
          addr_d  = param_raddr & AMASK;
          rem_d   = param_iolen;
          state_d = (param_iolen != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (!avm_waitrequest) begin
          beats_d = bc_w;
          addr_d  = addr_q + (XAW'(bc_w) << LG);
          rem_d   = rem_q - CW'(bc_w);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (avm_readdatavalid) begin
          beats_d = beats_q - 1'b1;
          if (beats_q == BW'(1)) begin
            state_d = (rem_q != '0) ? S_ISSUE : S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and the registered FIFO/done outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      done_q  <= (state_q == S_DONE);
      wr_q    <= beat_ok;
      if (beat_ok) begin
        wdata_q <= avm_readdata;
      end
    end
  end

  assign avm_read        = (state_q == S_ISSUE);
  assign avm_address     = addr_q;
  assign avm_burstcount  = (state_q == S_ISSUE) ? bc_w : '0;
  assign busy            = (state_q != S_IDLE);
  assign load_trans_done = done_q;
  assign fifo_wr         = wr_q;
  assign fifo_wdata      = wdata_q;

endmodule

// File: tb/tb_rmst_burst_engine.sv
// tb_rmst_burst_engine: directed checks of burst splitting, stalls,
// zero length, misalignment, ignored starts and reset abort.
module tb_rmst_burst_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_trans_start = 1'b0;
  logic [31:0]  param_raddr = '0;
  logic [15:0]  param_iolen = '0;
  logic         load_trans_done;
  logic [31:0]  avm_address;
  logic         avm_read;
  logic [4:0]   avm_burstcount;
  logic         avm_waitrequest = 1'b0;
  logic [127:0] avm_readdata = '0;
  logic         avm_readdatavalid = 1'b0;
  logic         fifo_wr;
  logic [127:0] fifo_wdata;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int dcnt = 0;

  logic [127:0] pq[$];
  logic [31:0]  aq_addr[$];
  logic [4:0]   aq_bc[$];
  int           done_cnt = 0;
  int           rd_cyc = 0;

  int pbase, abase, dbase, dnbase, rbase;

  rmst_burst_engine dut (
    .clk               (clk),
    .rst               (rst),
    .load_trans_start  (load_trans_start),
    .param_raddr       (param_raddr),
    .param_iolen       (param_iolen),
    .load_trans_done   (load_trans_done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .fifo_wr           (fifo_wr),
    .fifo_wdata        (fifo_wdata),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Passive record of pushes, dones, read cycles and accepted bursts.
  always @(posedge clk) begin
    if (fifo_wr === 1'b1) pq.push_back(fifo_wdata);
    if (load_trans_done === 1'b1) done_cnt++;
    if (avm_read === 1'b1) rd_cyc++;
    if (avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
      aq_addr.push_back(avm_address);
      aq_bc.push_back(avm_burstcount);
    end
  end

  function automatic logic [127:0] mk(input int id);
    logic [31:0] v;
    v = 32'(id);
    return {v, 32'hC0DE_0000 ^ v, ~v, 32'h1234_5678 + v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic beats(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          avm_readdatavalid = 1'b0;
          step();
        end
      end
      avm_readdatavalid = 1'b1;
      avm_readdata = mk(dcnt);
      dcnt++;
      step();
    end
    avm_readdatavalid = 1'b0;
  endtask

  task automatic mark();
    pbase  = pq.size();
    abase  = aq_addr.size();
    dbase  = dcnt;
    dnbase = done_cnt;
    rbase  = rd_cyc;
  endtask

  task automatic chk_data(input string tag, input int n);
    chk({tag, "_cnt"}, 160'(pq.size() - pbase), 160'(n));
    for (int i = 0; i < n; i++) begin
      chk(tag, pq[pbase + i], mk(dbase + i));
    end
  endtask

  task automatic chk_burst(input string tag, input int k,
                           input logic [31:0] a, input logic [4:0] b);
    chk(tag, {aq_addr[abase + k], aq_bc[abase + k]}, {a, b});
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_read", 160'(avm_read), 160'(0));
    chk("rst_addr", 160'(avm_address), 160'(0));
    chk("rst_bc", 160'(avm_burstcount), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_wr", 160'(fifo_wr), 160'(0));
    chk("rst_done", 160'(load_trans_done), 160'(0));
    rst = 1'b1;
    step();

    // basic: 18 beats -> 16 + 2
    mark();
    load_trans_start = 1'b1;
    param_raddr = 32'h0001_0000;
    param_iolen = 16'd18;
    step();
    load_trans_start = 1'b0;
    chk("b_iss1", {avm_read, avm_address, avm_burstcount},
        {1'b1, 32'h0001_0000, 5'd16});
    chk("b_busy", 160'(busy), 160'(1));
    step();
    chk("b_data_rd", 160'(avm_read), 160'(0));
    beats(16, 1'b0);
    chk("b_iss2", {avm_read, avm_address, avm_burstcount},
        {1'b1, 32'h0001_0100, 5'd2});
    step();
    beats(2, 1'b0);
    chk("b_lastwr", {fifo_wr, load_trans_done}, {1'b1, 1'b0});
    step();
    chk("b_done", {load_trans_done, busy}, {1'b1, 1'b0});
    step();
    chk("b_done_off", 160'(load_trans_done), 160'(0));
    chk_data("b_data", 18);
    chk("b_nbursts", 160'(aq_addr.size() - abase), 160'(2));
    chk_burst("b_burst0", 0, 32'h0001_0000, 5'd16);
    chk_burst("b_burst1", 1, 32'h0001_0100, 5'd2);
    chk("b_ndone", 160'(done_cnt - dnbase), 160'(1));

    // stall: waitrequest high for 3 cycles
    mark();
    load_trans_start = 1'b1;
    param_raddr = 32'h0000_2000;
    param_iolen = 16'd4;
    avm_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      load_trans_start = 1'b0;
      chk("s_hold", {avm_read, avm_address, avm_burstcount},
          {1'b1, 32'h0000_2000, 5'd4});
    end
    avm_waitrequest = 1'b0;
    step();
    chk("s_data_rd", 160'(avm_read), 160'(0));
    beats(4, 1'b0);
    chk("s_lastwr", 160'(fifo_wr), 160'(1));
    step();
    chk("s_done", 160'(load_trans_done), 160'(1));
    chk("s_naccept", 160'(aq_addr.size() - abase), 160'(1));
    chk_data("s_data", 4);

    // zero length
    step();
    mark();
    load_trans_start = 1'b1;
    param_raddr = 32'h0000_5000;
    param_iolen = 16'd0;
    step();
    load_trans_start = 1'b0;
    chk("z_t1", {avm_read, busy, load_trans_done}, {1'b0, 1'b1, 1'b0});
    step();
    chk("z_t2", {avm_read, load_trans_done}, {1'b0, 1'b1});
    step();
    chk("z_t3", 160'(load_trans_done), 160'(0));
    chk("z_noread", 160'(rd_cyc - rbase), 160'(0));

    // misaligned start, gapped data
    mark();
    load_trans_start = 1'b1;
    param_raddr = 32'h0000_1004;
    param_iolen = 16'd32;
    step();
    load_trans_start = 1'b0;
    chk("m_iss1", {avm_read, avm_address, avm_burstcount},
        {1'b1, 32'h0000_1000, 5'd16});
    step();
    beats(16, 1'b1);
    chk("m_rdcyc", 160'(rd_cyc - rbase), 160'(1));
    chk("m_iss2", {avm_read, avm_address, avm_burstcount},
        {1'b1, 32'h0000_1100, 5'd16});
    step();
    beats(16, 1'b1);
    step();
    chk("m_done", 160'(load_trans_done), 160'(1));
    chk_data("m_data", 32);
    chk_burst("m_burst1", 1, 32'h0000_1100, 5'd16);

    // second start during DATA is ignored
    step();
    mark();
    load_trans_start = 1'b1;
    param_raddr = 32'h0000_3000;
    param_iolen = 16'd3;
    step();
    load_trans_start = 1'b0;
    step();
    load_trans_start = 1'b1;
    param_raddr = 32'h0000_9000;
    param_iolen = 16'd5;
    avm_readdatavalid = 1'b1;
    avm_readdata = mk(dcnt);
    dcnt++;
    step();
    load_trans_start = 1'b0;
    beats(2, 1'b0);
    step();
    chk("i_done", 160'(load_trans_done), 160'(1));
    repeat (3) step();
    chk("i_idle", {busy, avm_read}, {1'b0, 1'b0});
    chk("i_ndone", 160'(done_cnt - dnbase), 160'(1));
    chk("i_naccept", 160'(aq_addr.size() - abase), 160'(1));
    chk_burst("i_burst0", 0, 32'h0000_3000, 5'd3);
    chk_data("i_data", 3);

    // reset mid-DATA aborts the segment
    mark();
    load_trans_start = 1'b1;
    param_raddr = 32'h0000_4000;
    param_iolen = 16'd8;
    step();
    load_trans_start = 1'b0;
    step();
    beats(3, 1'b0);
    chk("a_pre", {busy, fifo_wr}, {1'b1, 1'b1});
    rst = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = mk(900);
    step();
    chk("a_zero", {avm_read, avm_address, avm_burstcount, fifo_wr,
                   load_trans_done, busy}, 160'(0));
    chk("a_wdata", 160'(fifo_wdata), 160'(0));
    rst = 1'b1;
    avm_readdatavalid = 1'b0;
    beats(3, 1'b0);
    repeat (3) step();
    chk("a_npush", 160'(pq.size() - pbase), 160'(3));
    chk("a_ndone", 160'(done_cnt - dnbase), 160'(0));
    chk("a_idle", {busy, avm_read, fifo_wr}, {1'b0, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
